// File: rtl/mem_if.sv
// Bus bundle for the memory-access stage: exe2mem head, data-memory port,
// mem2wbk buffer head and bypass outputs.
interface mem_if;
    // exe2mem FIFO head
    logic        EXE2MEM_EMPTY_SE;
    logic [31:0] RES_RE;
    logic [31:0] MEM_DATA_RE;
    logic [5:0]  DEST_RE;
    logic [1:0]  MEM_SIZE_RE;
    logic        WB_RE;
    logic        MEM_LOAD_RE;
    logic        MEM_STORE_RE;
    logic        MEM_SIGN_EXTEND_RE;
    logic        CSR_WENABLE_RE;
    logic [31:0] CSR_RDATA_RE;
    logic        MULT_INST_RE;
    logic        EXCEPTION_RE;
    logic [31:0] PC_EXE2MEM_RE;
    logic        EXE2MEM_POP_SM;
    // data-memory request/response
    logic [31:0] MCACHE_ADR_SM;
    logic [31:0] MCACHE_DATA_SM;
    logic [3:0]  MCACHE_BYTE_EN_SM;
    logic        MCACHE_ADR_VALID_SM;
    logic        MCACHE_STORE_SM;
    logic        MCACHE_LOAD_SM;
    logic        MCACHE_STALL_SM;
    logic        MCACHE_RDATA_VALID_SM;
    logic [31:0] MCACHE_RESULT_SM;
    // mem2wbk buffer head / bypass
    logic        MEM2WBK_POP_SW;
    logic        MEM2WBK_EMPTY_SM;
    logic        BP_MEM2WBK_EMPTY_SM;
    logic [31:0] MEM_RES_RM;
    logic [5:0]  MEM_DEST_RM;
    logic        WB_RM;
    logic        CSR_WENABLE_RM;
    logic        MULT_INST_RM;
    logic [31:0] CSR_RDATA_RM;
    logic [31:0] PC_MEM2WBK_RM;
    logic        EXCEPTION_SM;

    // Stage side
    modport slave (
        input  EXE2MEM_EMPTY_SE, RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
               MEM_LOAD_RE, MEM_STORE_RE, MEM_SIGN_EXTEND_RE, CSR_WENABLE_RE,
               CSR_RDATA_RE, MULT_INST_RE, EXCEPTION_RE, PC_EXE2MEM_RE,
               MCACHE_STALL_SM, MCACHE_RDATA_VALID_SM, MCACHE_RESULT_SM, MEM2WBK_POP_SW,
        output EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_BYTE_EN_SM,
               MCACHE_ADR_VALID_SM, MCACHE_STORE_SM, MCACHE_LOAD_SM,
               MEM2WBK_EMPTY_SM, BP_MEM2WBK_EMPTY_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
               CSR_WENABLE_RM, MULT_INST_RM, CSR_RDATA_RM, PC_MEM2WBK_RM, EXCEPTION_SM
    );

    // Surrounding pipeline / memory side
    modport master (
        output EXE2MEM_EMPTY_SE, RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
               MEM_LOAD_RE, MEM_STORE_RE, MEM_SIGN_EXTEND_RE, CSR_WENABLE_RE,
               CSR_RDATA_RE, MULT_INST_RE, EXCEPTION_RE, PC_EXE2MEM_RE,
               MCACHE_STALL_SM, MCACHE_RDATA_VALID_SM, MCACHE_RESULT_SM, MEM2WBK_POP_SW,
        input  EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_BYTE_EN_SM,
               MCACHE_ADR_VALID_SM, MCACHE_STORE_SM, MCACHE_LOAD_SM,
               MEM2WBK_EMPTY_SM, BP_MEM2WBK_EMPTY_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
               CSR_WENABLE_RM, MULT_INST_RM, CSR_RDATA_RM, PC_MEM2WBK_RM, EXCEPTION_SM
    );
endinterface

// File: rtl/mem.sv
// Memory-access stage: issues loads/stores, formats load data and feeds a
// 2-entry mem2wbk buffer whose head also drives the exe bypass.
module mem (
    input  logic clk,
    input  logic reset,
    mem_if.slave bus
);
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  dest;
        logic        wb;
        logic        csr_we;
        logic [31:0] csr_rdata;
        logic        mult;
        logic [31:0] pc;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           buf_q [BUF_DEPTH];
    logic             rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rsp_q, rsp_d;
    logic             rsp_vld_q, rsp_vld_d;

    logic        head_vld, mem_op, wbk_pop, can_push, buf_empty;
    logic        push, req;
    entry_t      push_ent, head_ent;
    logic [31:0] load_word, load_shift, load_fmt, st_data;
    logic [3:0]  byte_en;
    logic [1:0]  addr_lo;

    assign head_vld  = ~bus.EXE2MEM_EMPTY_SE;
    assign mem_op    = (bus.MEM_LOAD_RE | bus.MEM_STORE_RE) & ~bus.EXCEPTION_RE;
    assign buf_empty = (cnt_q == '0);
    assign wbk_pop   = bus.MEM2WBK_POP_SW & ~buf_empty;
    assign can_push  = (cnt_q != CNT_W'(BUF_DEPTH)) | wbk_pop;
    assign addr_lo   = bus.RES_RE[1:0];

    // Load alignment and extension; a latched response takes priority
    always_comb begin
        load_word  = rsp_vld_q ? rsp_q : bus.MCACHE_RESULT_SM;
        load_shift = load_word >> {addr_lo, 3'b000};
        load_fmt   = load_word;
        case (bus.MEM_SIZE_RE)
            2'b01:   load_fmt = {{16{bus.MEM_SIGN_EXTEND_RE & load_shift[15]}}, load_shift[15:0]};
            2'b10:   load_fmt = {{24{bus.MEM_SIGN_EXTEND_RE & load_shift[7]}}, load_shift[7:0]};
            default: load_fmt = load_word;
        endcase
    end

    // Store byte enables and lane-replicated store data
    always_comb begin
        byte_en = 4'b1111;
        st_data = bus.MEM_DATA_RE;
        case (bus.MEM_SIZE_RE)
            2'b01: begin
                byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                st_data = {2{bus.MEM_DATA_RE[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b0001 << addr_lo;
                st_data = {4{bus.MEM_DATA_RE[7:0]}};
            end
            default: ;
        endcase
    end

    // Next-state, request and push decisions
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        rsp_vld_d = rsp_vld_q;
        push      = 1'b0;
        req       = 1'b0;
        push_ent.res       = bus.RES_RE;
        push_ent.dest      = bus.DEST_RE;
        push_ent.wb        = bus.WB_RE & ~bus.EXCEPTION_RE;
        push_ent.csr_we    = bus.CSR_WENABLE_RE;
        push_ent.csr_rdata = bus.CSR_RDATA_RE;
        push_ent.mult      = bus.MULT_INST_RE;
        push_ent.pc        = bus.PC_EXE2MEM_RE;
        case (state_q)
            IDLE: begin
                if (head_vld && can_push) begin
                    if (!mem_op) begin
                        push = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!bus.MCACHE_STALL_SM) begin
                            if (bus.MEM_STORE_RE) begin
                                push        = 1'b1;
                                push_ent.wb = 1'b0;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                if (rsp_vld_q || bus.MCACHE_RDATA_VALID_SM) begin
                    if (can_push) begin
                        push         = 1'b1;
                        push_ent.res = load_fmt;
                        push_ent.wb  = bus.WB_RE;
                        rsp_vld_d    = 1'b0;
                        state_d      = IDLE;
                    end else if (!rsp_vld_q) begin
                        rsp_d     = bus.MCACHE_RESULT_SM;
                        rsp_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            push = 1'b0;
            req  = 1'b0;
        end
    end

    // FSM state, response latch and buffer storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            rsp_vld_q <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            rsp_vld_q <= rsp_vld_d;
            if (push) begin
                buf_q[wr_ptr_q] <= push_ent;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (wbk_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(wbk_pop);
        end
    end

    assign head_ent = buf_q[rd_ptr_q];

    assign bus.EXE2MEM_POP_SM      = push;
    assign bus.MCACHE_ADR_SM       = bus.RES_RE;
    assign bus.MCACHE_DATA_SM      = st_data;
    assign bus.MCACHE_BYTE_EN_SM   = byte_en;
    assign bus.MCACHE_ADR_VALID_SM = req;
    assign bus.MCACHE_LOAD_SM      = req & bus.MEM_LOAD_RE;
    assign bus.MCACHE_STORE_SM     = req & bus.MEM_STORE_RE;
    assign bus.EXCEPTION_SM        = ~reset & head_vld & bus.EXCEPTION_RE;

    assign bus.MEM2WBK_EMPTY_SM    = buf_empty;
    assign bus.BP_MEM2WBK_EMPTY_SM = buf_empty;
    assign bus.MEM_RES_RM          = buf_empty ? 32'd0 : head_ent.res;
    assign bus.MEM_DEST_RM         = buf_empty ? 6'd0  : head_ent.dest;
    assign bus.WB_RM               = ~buf_empty & head_ent.wb;
    assign bus.CSR_WENABLE_RM      = ~buf_empty & head_ent.csr_we;
    assign bus.MULT_INST_RM        = ~buf_empty & head_ent.mult;
    assign bus.CSR_RDATA_RM        = buf_empty ? 32'd0 : head_ent.csr_rdata;
    assign bus.PC_MEM2WBK_RM       = buf_empty ? 32'd0 : head_ent.pc;
endmodule
